// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 byte constants, FSM state, phase and error-code encodings
// Revision: 1.0
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_BAT_FAIL  = 8'hFC;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_TX  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_WAIT_BAT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_ACK_TMO = 2'd0,
    ERR_RETRY   = 2'd1,
    ERR_BAT     = 2'd2,
    ERR_TX      = 2'd3
  } err_t;

  typedef enum logic {
    PH_CMD = 1'b0,
    PH_ARG = 1'b1
  } phase_t;

endpackage

`default_nettype wire

// File: rtl/ps2_timeout_timer.sv
// ps2_timeout_timer: clearable up-counter with a terminal-count flag against a runtime limit
// Revision: 1.0
`default_nettype none

module ps2_timeout_timer #(
  parameter int TMR_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [TMR_W-1:0] i_limit,
  output logic             o_tc
);

  logic [TMR_W-1:0] r_count;
  logic [TMR_W-1:0] w_count_inc;

  assign w_count_inc = r_count + TMR_W'(1);
  // Flag the cycle in which the count steps onto limit-1, so the registered
  // error lands exactly `limit` cycles after the clear.
  assign o_tc = i_en && (w_count_inc == (i_limit - TMR_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_count_inc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_cmd_sequencer.sv
// ps2_cmd_sequencer: sequences 1-2 byte PS/2 device commands, consumes ACK/RESEND/BAT, forwards other bytes
// Revision: 1.0
`default_nettype none

module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT = 200000,
  parameter int BAT_TIMEOUT = 7500000,
  parameter int MAX_RETRY   = 3,
  parameter int TMR_W       = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [7:0] i_cmd_byte,
  input  logic       i_cmd_has_arg,
  input  logic [7:0] i_cmd_arg,
  output logic       o_cmd_done,
  output logic       o_cmd_err,
  output logic [1:0] o_err_code,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_done,
  input  logic       i_tx_err,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_host_valid,
  output logic [7:0] o_host_data,
  output logic       o_busy
);

  localparam int                     c_retry_w   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [c_retry_w-1:0]   c_max_retry = c_retry_w'(MAX_RETRY);
  localparam logic [TMR_W-1:0]       c_ack_lim   = TMR_W'(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0]       c_bat_lim   = TMR_W'(BAT_TIMEOUT);

  state_t               r_state,      w_state;
  phase_t               r_phase,      w_phase;
  logic [c_retry_w-1:0] r_retry,      w_retry;
  logic [7:0]           r_cmd,        w_cmd;
  logic [7:0]           r_arg,        w_arg;
  logic                 r_has_arg,    w_has_arg;
  logic                 r_tx_start,   w_tx_start;
  logic [7:0]           r_tx_data,    w_tx_data;
  logic                 r_cmd_done,   w_cmd_done;
  logic                 r_cmd_err,    w_cmd_err;
  err_t                 r_err_code,   w_err_code;
  logic                 r_host_valid, w_host_valid;
  logic [7:0]           r_host_data,  w_host_data;

  logic                 w_tmr_clr, w_tmr_en, w_tmr_tc;
  logic [TMR_W-1:0]     w_tmr_limit;
  logic                 w_consumed, w_resend, w_resend_tx;

  assign w_tmr_en    = (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_BAT);
  assign w_tmr_limit = (r_state == ST_WAIT_BAT) ? c_bat_lim : c_ack_lim;

  ps2_timeout_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_limit (w_tmr_limit),
    .o_tc    (w_tmr_tc)
  );

  always_comb begin
    w_state      = r_state;
    w_phase      = r_phase;
    w_retry      = r_retry;
    w_cmd        = r_cmd;
    w_arg        = r_arg;
    w_has_arg    = r_has_arg;
    w_tx_start   = 1'b0;
    w_tx_data    = r_tx_data;
    w_cmd_done   = 1'b0;
    w_cmd_err    = 1'b0;
    w_err_code   = r_err_code;
    w_host_valid = 1'b0;
    w_host_data  = r_host_data;
    w_tmr_clr    = 1'b0;
    w_consumed   = 1'b0;
    w_resend     = 1'b0;
    w_resend_tx  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_cmd      = i_cmd_byte;
          w_arg      = i_cmd_arg;
          w_has_arg  = i_cmd_has_arg;
          w_phase    = PH_CMD;
          w_retry    = '0;
          w_err_code = ERR_ACK_TMO;
          w_state    = ST_SEND;
        end
      end
      ST_SEND: begin
        w_tx_data  = (r_phase == PH_ARG) ? r_arg : r_cmd;
        w_tx_start = 1'b1;
        w_state    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done && !i_tx_err) begin
          w_tmr_clr = 1'b1;
          w_state   = ST_WAIT_ACK;
        end else if (i_tx_done) begin
          w_resend    = 1'b1;
          w_resend_tx = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        // A response on the timeout cycle wins over the timeout.
        if (i_rx_valid && (i_rx_data == PS2_ACK)) begin
          w_consumed = 1'b1;
          if ((r_phase == PH_CMD) && r_has_arg) begin
            w_phase = PH_ARG;
            w_retry = '0;
            w_state = ST_SEND;
          end else if (r_cmd == PS2_CMD_RESET) begin
            w_tmr_clr = 1'b1;
            w_state   = ST_WAIT_BAT;
          end else begin
            w_cmd_done = 1'b1;
            w_state    = ST_IDLE;
          end
        end else if (i_rx_valid && (i_rx_data == PS2_RESEND)) begin
          w_consumed = 1'b1;
          w_resend   = 1'b1;
        end else if (w_tmr_tc) begin
          w_err_code = ERR_ACK_TMO;
          w_cmd_err  = 1'b1;
          w_state    = ST_IDLE;
        end
      end
      ST_WAIT_BAT: begin
        if (i_rx_valid && (i_rx_data == PS2_BAT_OK)) begin
          w_consumed = 1'b1;
          w_cmd_done = 1'b1;
          w_state    = ST_IDLE;
        end else if ((i_rx_valid && (i_rx_data == PS2_BAT_FAIL)) || w_tmr_tc) begin
          w_consumed = i_rx_valid && (i_rx_data == PS2_BAT_FAIL);
          w_err_code = ERR_BAT;
          w_cmd_err  = 1'b1;
          w_state    = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase

    if (w_resend) begin
      if (r_retry < c_max_retry) begin
        w_retry = r_retry + c_retry_w'(1);
        w_state = ST_SEND;
      end else begin
        w_err_code = w_resend_tx ? ERR_TX : ERR_RETRY;
        w_cmd_err  = 1'b1;
        w_state    = ST_IDLE;
      end
    end

    if (i_rx_valid && !w_consumed) begin
      w_host_valid = 1'b1;
      w_host_data  = i_rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_phase      <= PH_CMD;
      r_retry      <= '0;
      r_cmd        <= '0;
      r_arg        <= '0;
      r_has_arg    <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_cmd_done   <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_err_code   <= ERR_ACK_TMO;
      r_host_valid <= 1'b0;
      r_host_data  <= '0;
    end else begin
      r_state      <= w_state;
      r_phase      <= w_phase;
      r_retry      <= w_retry;
      r_cmd        <= w_cmd;
      r_arg        <= w_arg;
      r_has_arg    <= w_has_arg;
      r_tx_start   <= w_tx_start;
      r_tx_data    <= w_tx_data;
      r_cmd_done   <= w_cmd_done;
      r_cmd_err    <= w_cmd_err;
      r_err_code   <= w_err_code;
      r_host_valid <= w_host_valid;
      r_host_data  <= w_host_data;
    end
  end

  assign o_cmd_ready  = (r_state == ST_IDLE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_tx_start   = r_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_cmd_done   = r_cmd_done;
  assign o_cmd_err    = r_cmd_err;
  assign o_err_code   = r_err_code;
  assign o_host_valid = r_host_valid;
  assign o_host_data  = r_host_data;

endmodule

`default_nettype wire

// File: tb/tb_ps2_cmd_sequencer.sv
// tb_ps2_cmd_sequencer: scoreboard bench driving a scripted keyboard against ps2_cmd_sequencer
// Revision: 1.0
`default_nettype none

module tb_ps2_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_has_arg = 1'b0;
  logic [7:0] cmd_byte = 8'h00, cmd_arg = 8'h00;
  logic       tx_done = 1'b0, tx_err = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       o_cmd_ready, o_cmd_done, o_cmd_err, o_tx_start, o_host_valid, o_busy;
  logic [1:0] o_err_code;
  logic [7:0] o_tx_data, o_host_data;

  ps2_cmd_sequencer #(
    .ACK_TIMEOUT (50),
    .BAT_TIMEOUT (200),
    .MAX_RETRY   (3),
    .TMR_W       (23)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_byte    (cmd_byte),
    .i_cmd_has_arg (cmd_has_arg),
    .i_cmd_arg     (cmd_arg),
    .o_cmd_done    (o_cmd_done),
    .o_cmd_err     (o_cmd_err),
    .o_err_code    (o_err_code),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .i_tx_done     (tx_done),
    .i_tx_err      (tx_err),
    .i_rx_valid    (rx_valid),
    .i_rx_data     (rx_data),
    .o_host_valid  (o_host_valid),
    .o_host_data   (o_host_data),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Event encoding {done, err, err_code}
  localparam logic [3:0] EV_DONE = 4'b1000;
  function automatic logic [3:0] ev_err(input logic [1:0] code);
    return {2'b01, code};
  endfunction

  logic [7:0] exp_tx[$];
  logic [7:0] exp_host[$];
  logic [3:0] exp_evt[$];
  int tx_cnt = 0, host_cnt = 0, evt_cnt = 0;
  int last_tx_cyc = 0, host_cyc = 0, evt_cyc = 0;
  int tx_taken = 0, evt_taken = 0;
  int acc_cyc = 0, txd_cyc = 0, rx_cyc = 0;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (o_tx_start) begin
        tx_cnt++;
        last_tx_cyc = cyc;
        check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) check("tx_data", 32'(o_tx_data), 32'(exp_tx.pop_front()));
      end
      if (o_host_valid) begin
        host_cnt++;
        host_cyc = cyc;
        check("host_expected", 32'(exp_host.size() != 0), 32'd1);
        if (exp_host.size() != 0) check("host_data", 32'(o_host_data), 32'(exp_host.pop_front()));
      end
      if (o_cmd_done || o_cmd_err) begin
        evt_cnt++;
        evt_cyc = cyc;
        check("evt_expected", 32'(exp_evt.size() != 0), 32'd1);
        if (exp_evt.size() != 0)
          check("evt_done_err_code", 32'({o_cmd_done, o_cmd_err, o_err_code}), 32'(exp_evt.pop_front()));
      end
    end
  end

  task automatic send_cmd(input logic [7:0] c, input logic ha, input logic [7:0] a);
    @(negedge clk);
    for (int i = 0; i < 50 && !o_cmd_ready; i++) @(negedge clk);
    check("ready_before_cmd", 32'(o_cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_byte = c; cmd_has_arg = ha; cmd_arg = a;
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for the next tx_start, then complete the frame; optionally land an rx byte on the tx_done cycle.
  task automatic do_tx(input logic err, input logic rx_too, input logic [7:0] rb);
    for (int i = 0; i < 40 && tx_cnt == tx_taken; i++) @(negedge clk);
    check("tx_start_seen", 32'(tx_cnt > tx_taken), 32'd1);
    tx_taken = tx_cnt;
    @(negedge clk);
    @(negedge clk);
    tx_done = 1'b1; tx_err = err;
    rx_valid = rx_too; rx_data = rb;
    txd_cyc = cyc;
    @(negedge clk);
    tx_done = 1'b0; tx_err = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    rx_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_evt(input int maxc);
    for (int i = 0; i < maxc && evt_cnt == evt_taken; i++) @(negedge clk);
    check("evt_seen", 32'(evt_cnt > evt_taken), 32'd1);
    evt_taken = evt_cnt;
  endtask

  task automatic end_test();
    repeat (3) @(negedge clk);
    check("tx_queue_drained",   32'(exp_tx.size()),   32'd0);
    check("host_queue_drained", 32'(exp_host.size()), 32'd0);
    check("evt_queue_drained",  32'(exp_evt.size()),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready",     32'(o_cmd_ready),  32'd1);
    check("rst_busy",      32'(o_busy),       32'd0);
    check("rst_tx_data",   32'(o_tx_data),    32'd0);
    check("rst_err_code",  32'(o_err_code),   32'd0);
    check("rst_host_data", 32'(o_host_data),  32'd0);

    // Set LEDs: two bytes, each ACKed
    exp_tx.push_back(8'hED); exp_tx.push_back(8'h02); exp_evt.push_back(EV_DONE);
    send_cmd(8'hED, 1'b1, 8'h02);
    do_tx(1'b0, 1'b0, 8'h00);
    check("accept_to_tx_start", 32'(last_tx_cyc - acc_cyc), 32'd2);
    rx(8'hFA);
    do_tx(1'b0, 1'b0, 8'h00);
    rx(8'hFA);
    wait_evt(20);
    check("ack_to_done", 32'(evt_cyc - rx_cyc), 32'd1);
    end_test();

    // Two resends then ACK
    repeat (3) exp_tx.push_back(8'hF4);
    exp_evt.push_back(EV_DONE);
    send_cmd(8'hF4, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      do_tx(1'b0, 1'b0, 8'h00);
      rx((i < 2) ? 8'hFE : 8'hFA);
    end
    wait_evt(20);
    end_test();

    // Four resends: retries exhausted
    repeat (4) exp_tx.push_back(8'hF4);
    exp_evt.push_back(ev_err(2'd1));
    send_cmd(8'hF4, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      do_tx(1'b0, 1'b0, 8'h00);
      rx(8'hFE);
    end
    wait_evt(20);
    end_test();

    // Four line-level tx errors
    repeat (4) exp_tx.push_back(8'hF5);
    exp_evt.push_back(ev_err(2'd3));
    send_cmd(8'hF5, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) do_tx(1'b1, 1'b0, 8'h00);
    wait_evt(20);
    end_test();

    // Reset command: BAT ok, BAT fail, BAT timeout
    for (int k = 0; k < 3; k++) begin
      exp_tx.push_back(8'hFF);
      exp_evt.push_back((k == 0) ? EV_DONE : ev_err(2'd2));
      send_cmd(8'hFF, 1'b0, 8'h00);
      do_tx(1'b0, 1'b0, 8'h00);
      rx(8'hFA);
      if (k == 0) begin
        repeat (10) @(negedge clk);
        rx(8'hAA);
        wait_evt(20);
      end else if (k == 1) begin
        repeat (10) @(negedge clk);
        rx(8'hFC);
        wait_evt(20);
      end else begin
        wait_evt(300);
        check("bat_timeout_latency", 32'(evt_cyc - rx_cyc), 32'd200);
      end
      end_test();
    end

    // ACK timeout
    exp_tx.push_back(8'hF4);
    exp_evt.push_back(ev_err(2'd0));
    send_cmd(8'hF4, 1'b0, 8'h00);
    do_tx(1'b0, 1'b0, 8'h00);
    wait_evt(100);
    check("ack_timeout_latency", 32'(evt_cyc - txd_cyc), 32'd50);
    @(negedge clk);
    check("ready_after_err", 32'(o_cmd_ready), 32'd1);
    end_test();

    // Interleaved scan codes: one on the tx_done cycle, one during WAIT_ACK
    exp_tx.push_back(8'hF4);
    exp_host.push_back(8'h2D); exp_host.push_back(8'h1C);
    exp_evt.push_back(EV_DONE);
    send_cmd(8'hF4, 1'b0, 8'h00);
    do_tx(1'b0, 1'b1, 8'h2D);
    rx(8'h1C);
    check("host_latency", 32'(host_cyc - rx_cyc), 32'd1);
    rx(8'hFA);
    wait_evt(20);
    end_test();

    // ACK/RESEND while idle are forwarded
    exp_host.push_back(8'hFA); exp_host.push_back(8'hFE);
    rx(8'hFA);
    rx(8'hFE);
    end_test();

    // Reset during WAIT_ACK abandons silently
    exp_tx.push_back(8'hF4);
    send_cmd(8'hF4, 1'b0, 8'h00);
    do_tx(1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("busy_before_rst", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_busy",    32'(o_busy),      32'd0);
    check("rst_mid_ready",   32'(o_cmd_ready), 32'd1);
    check("rst_mid_tx_data", 32'(o_tx_data),   32'd0);
    end_test();

    // Recovery after mid-command reset
    exp_tx.push_back(8'hF6); exp_evt.push_back(EV_DONE);
    send_cmd(8'hF6, 1'b0, 8'h00);
    do_tx(1'b0, 1'b0, 8'h00);
    rx(8'hFA);
    wait_evt(20);
    end_test();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
